// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (icache / dcache) arbiter in front of a single RAM.
//            One transaction at a time; IDLE decides the grant, the serve
//            state drives the RAM request until ramstate reports ACCESS or
//            ERROR, or the requester withdraws. When both ports contend, the
//            grant alternates based on the last successfully completed grant.
// Ports    : CLK, nRST (async, active-low)
//            icache : iREN, iaddr -> iwait, iload
//            dcache : dREN, dWEN, daddr, dstore -> dwait, dload
//            RAM    : ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate
//            status : icount, dcount (saturating completions), err (sticky)
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  output logic             iwait,
  output logic [31:0]      iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount,
  output logic             err
);

  localparam logic [1:0] c_free   = 2'd0;
  localparam logic [1:0] c_busy   = 2'd1;
  localparam logic [1:0] c_access = 2'd2;
  localparam logic [1:0] c_error  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISERV = 2'd1,
    S_DSERV = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_d;
  logic [CNT_W-1:0] r_icount;
  logic [CNT_W-1:0] r_dcount;
  logic             r_err;

  logic             w_ireq;
  logic             w_dreq;
  logic             w_iack;
  logic             w_dack;
  logic             w_err_evt;

  assign w_ireq = iREN;
  assign w_dreq = dREN | dWEN;

  // --------------------------------------------------------------------------
  // State and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b0;
      r_icount <= '0;
      r_dcount <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_iack) begin
        r_last_d <= 1'b0;
        if (r_icount != '1) r_icount <= r_icount + CNT_W'(1);
      end
      if (w_dack) begin
        r_last_d <= 1'b1;
        if (r_dcount != '1) r_dcount <= r_dcount + CNT_W'(1);
      end
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'd0;
    ramstore  = 32'd0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = 32'd0;
    dload     = 32'd0;
    w_iack    = 1'b0;
    w_dack    = 1'b0;
    w_err_evt = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Contention: data wins unless data was the last completed grant.
        if (w_dreq && w_ireq) begin
          w_next = r_last_d ? S_ISERV : S_DSERV;
        end else if (w_dreq) begin
          w_next = S_DSERV;
        end else if (w_ireq) begin
          w_next = S_ISERV;
        end
      end

      S_ISERV: begin
        if (!w_ireq) begin
          // Requester withdrew: drop the RAM request, no ack.
          w_next = S_IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (ramstate)
            c_access: begin
              iwait  = 1'b0;
              iload  = ramload;
              w_iack = 1'b1;
              w_next = S_IDLE;
            end
            c_error: begin
              w_err_evt = 1'b1;
              w_next    = S_IDLE;
            end
            c_free, c_busy: w_next = S_ISERV;
            default:        w_next = S_ISERV;
          endcase
        end
      end

      S_DSERV: begin
        if (!w_dreq) begin
          w_next = S_IDLE;
        end else begin
          // A write takes precedence over a simultaneous read.
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          case (ramstate)
            c_access: begin
              dwait  = 1'b0;
              dload  = dWEN ? 32'd0 : ramload;
              w_dack = 1'b1;
              w_next = S_IDLE;
            end
            c_error: begin
              w_err_evt = 1'b1;
              w_next    = S_IDLE;
            end
            c_free, c_busy: w_next = S_DSERV;
            default:        w_next = S_DSERV;
          endcase
        end
      end

      default: w_next = S_IDLE;
    endcase
  end

  assign icount = r_icount;
  assign dcount = r_dcount;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A per-cycle vector table
//            (inputs + expected outputs) covers reset, single reads/writes,
//            contention ordering, errors, withdrawal and mid-transaction
//            reset; a hand-written loop covers counter saturation on a
//            CNT_W=4 instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;

  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [15:0] icount, dcount;

  logic        iwait4, dwait4, ramREN4, ramWEN4, err4;
  logic [31:0] iload4, dload4, ramaddr4, ramstore4;
  logic [3:0]  icount4, dcount4;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.CNT_W(16)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .icount(icount), .dcount(dcount), .err(err)
  );

  mem_arbiter #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait4), .iload(iload4),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait4), .dload(dload4),
    .ramREN(ramREN4), .ramWEN(ramWEN4), .ramaddr(ramaddr4), .ramstore(ramstore4),
    .ramload(ramload), .ramstate(ramstate),
    .icount(icount4), .dcount(dcount4), .err(err4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        rn, ir, dr, dw;
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_iw, e_dw;
    logic [31:0] e_il, e_dl;
    logic [15:0] e_ic, e_dc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rn, ir, dr, dw,
                     input logic [31:0] ia, da, ds, rl, input logic [1:0] rs,
                     input logic er, ew, input logic [31:0] ea, es,
                     input logic eiw, edw, input logic [31:0] eil, edl,
                     input logic [15:0] eic, edc, input logic ee);
    vec_t v;
    v.name = nm; v.rn = rn; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
    v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
    v.e_iw = eiw; v.e_dw = edw; v.e_il = eil; v.e_dl = edl;
    v.e_ic = eic; v.e_dc = edc; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Cycle in which no RAM request is expected and both ports stall.
  task automatic addi(input string nm, input logic rn, ir, dr, dw,
                      input logic [31:0] ia, da, ds, rl, input logic [1:0] rs,
                      input logic [15:0] eic, edc, input logic ee);
    add(nm, rn, ir, dr, dw, ia, da, ds, rl, rs,
        1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 32'd0, eic, edc, ee);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // reset state
    addi("rst",       0,0,0,0, 32'h0,  32'h0, 32'h0, 32'h0, FREE, 0,0,0);
    // single icache read, immediate ACCESS
    addi("i_idle",    1,1,0,0, 32'h100,32'h0, 32'h0, 32'hDEADBEEF, ACC, 0,0,0);
    add ("i_acc",     1,1,0,0, 32'h100,32'h0, 32'h0, 32'hDEADBEEF, ACC,
         1,0,32'h100,32'h0, 0,1, 32'hDEADBEEF,32'h0, 0,0,0);
    addi("i_done",    1,0,0,0, 32'h0,  32'h0, 32'h0, 32'h0, FREE, 1,0,0);
    // dcache write with simultaneous read, 3 BUSY then ACCESS
    addi("dw_idle",   1,0,1,1, 32'h0,32'h40,32'h12345678,32'h0, BUSY, 1,0,0);
    for (int k = 0; k < 3; k++)
      add("dw_busy",  1,0,1,1, 32'h0,32'h40,32'h12345678,32'h0, BUSY,
          0,1,32'h40,32'h12345678, 1,1, 32'h0,32'h0, 1,0,0);
    add ("dw_acc",    1,0,1,1, 32'h0,32'h40,32'h12345678,32'hAAAA5555, ACC,
         0,1,32'h40,32'h12345678, 1,0, 32'h0,32'h0, 1,0,0);
    addi("dw_done",   1,0,0,0, 32'h0,32'h0,32'h0,32'h0, FREE, 1,1,0);
    // contention: D, I, D, I starting from last_d=0
    addi("rst2",      0,0,0,0, 32'h0,32'h0,32'h0,32'h0, FREE, 0,0,0);
    addi("rr_idle0",  1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC, 0,0,0);
    add ("rr_d0",     1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC,
         1,0,32'h300,32'h0, 1,0, 32'h0,32'h11112222, 0,0,0);
    addi("rr_idle1",  1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC, 0,1,0);
    add ("rr_i1",     1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC,
         1,0,32'h200,32'h0, 0,1, 32'h11112222,32'h0, 0,1,0);
    addi("rr_idle2",  1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC, 1,1,0);
    add ("rr_d2",     1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC,
         1,0,32'h300,32'h0, 1,0, 32'h0,32'h11112222, 1,1,0);
    addi("rr_idle3",  1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC, 1,2,0);
    add ("rr_i3",     1,1,1,0, 32'h200,32'h300,32'h0,32'h11112222, ACC,
         1,0,32'h200,32'h0, 0,1, 32'h11112222,32'h0, 1,2,0);
    addi("rr_done",   1,0,0,0, 32'h0,32'h0,32'h0,32'h0, FREE, 2,2,0);
    // RAM error: sticky err, no count, last_d untouched
    addi("er_idle",   1,0,1,0, 32'h0,32'h44,32'h0,32'h0, ERR, 2,2,0);
    add ("er_serv",   1,0,1,0, 32'h0,32'h44,32'h0,32'h0, ERR,
         1,0,32'h44,32'h0, 1,1, 32'h0,32'h0, 2,2,0);
    addi("er_sticky", 1,0,0,0, 32'h0,32'h0,32'h0,32'h0, FREE, 2,2,1);
    addi("er_idle2",  1,1,1,0, 32'h200,32'h44,32'h0,32'h11112222, ACC, 2,2,1);
    add ("er_d",      1,1,1,0, 32'h200,32'h44,32'h0,32'h11112222, ACC,
         1,0,32'h44,32'h0, 1,0, 32'h0,32'h11112222, 2,2,1);
    addi("er_idle3",  1,1,1,0, 32'h200,32'h44,32'h0,32'h11112222, ACC, 2,3,1);
    add ("er_i",      1,1,1,0, 32'h200,32'h44,32'h0,32'h11112222, ACC,
         1,0,32'h200,32'h0, 0,1, 32'h11112222,32'h0, 2,3,1);
    addi("er_done",   1,0,0,0, 32'h0,32'h0,32'h0,32'h0, FREE, 3,3,1);
    // withdrawal while served, with address pass-through
    addi("ab_idle",   1,1,0,0, 32'h200,32'h0,32'h0,32'h0, BUSY, 3,3,1);
    add ("ab_busy",   1,1,0,0, 32'h200,32'h0,32'h0,32'h0, BUSY,
         1,0,32'h200,32'h0, 1,1, 32'h0,32'h0, 3,3,1);
    add ("ab_addr",   1,1,0,0, 32'h204,32'h0,32'h0,32'h0, BUSY,
         1,0,32'h204,32'h0, 1,1, 32'h0,32'h0, 3,3,1);
    addi("ab_drop",   1,0,0,0, 32'h204,32'h0,32'h0,32'h77, ACC, 3,3,1);
    addi("ab_after",  1,0,0,0, 32'h0,32'h0,32'h0,32'h77, ACC, 3,3,1);
    // reset in the middle of a BUSY data transaction
    addi("rs_idle",   1,0,1,0, 32'h0,32'h44,32'h0,32'h0, BUSY, 3,3,1);
    add ("rs_busy",   1,0,1,0, 32'h0,32'h44,32'h0,32'h0, BUSY,
         1,0,32'h44,32'h0, 1,1, 32'h0,32'h0, 3,3,1);
    addi("rs_rst",    0,0,1,0, 32'h0,32'h44,32'h0,32'h0, BUSY, 0,0,0);
    addi("rs_idle2",  1,1,1,0, 32'h200,32'h44,32'h0,32'h55AA55AA, ACC, 0,0,0);
    add ("rs_d",      1,1,1,0, 32'h200,32'h44,32'h0,32'h55AA55AA, ACC,
         1,0,32'h44,32'h0, 1,0, 32'h0,32'h55AA55AA, 0,0,0);
    addi("rs_done",   1,0,0,0, 32'h0,32'h0,32'h0,32'h0, FREE, 0,1,0);

    // Drive on the falling edge, sample 2 time units later.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      nRST = vecs[i].rn; iREN = vecs[i].ir; dREN = vecs[i].dr; dWEN = vecs[i].dw;
      iaddr = vecs[i].ia; daddr = vecs[i].da; dstore = vecs[i].ds;
      ramload = vecs[i].rl; ramstate = vecs[i].rs;
      #2;
      chk({vecs[i].name, ".ramREN"},   {31'd0, ramREN},   {31'd0, vecs[i].e_ren});
      chk({vecs[i].name, ".ramWEN"},   {31'd0, ramWEN},   {31'd0, vecs[i].e_wen});
      chk({vecs[i].name, ".ramaddr"},  ramaddr,           vecs[i].e_addr);
      chk({vecs[i].name, ".ramstore"}, ramstore,          vecs[i].e_store);
      chk({vecs[i].name, ".iwait"},    {31'd0, iwait},    {31'd0, vecs[i].e_iw});
      chk({vecs[i].name, ".dwait"},    {31'd0, dwait},    {31'd0, vecs[i].e_dw});
      chk({vecs[i].name, ".iload"},    iload,             vecs[i].e_il);
      chk({vecs[i].name, ".dload"},    dload,             vecs[i].e_dl);
      chk({vecs[i].name, ".icount"},   {16'd0, icount},   {16'd0, vecs[i].e_ic});
      chk({vecs[i].name, ".dcount"},   {16'd0, dcount},   {16'd0, vecs[i].e_dc});
      chk({vecs[i].name, ".err"},      {31'd0, err},      {31'd0, vecs[i].e_err});
    end

    // Saturation on the CNT_W=4 instance: 16 back-to-back icache reads.
    @(negedge CLK);
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h8; ramload = 32'hCAFE0000; ramstate = ACC;
    #2;
    chk("sat.rst_icount4", {28'd0, icount4}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1; iREN = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #2;
      chk("sat.idle_iwait",   {31'd0, iwait4},  32'd1);
      chk("sat.idle_ramREN",  {31'd0, ramREN4}, 32'd0);
      chk("sat.icount4",      {28'd0, icount4}, (k - 1 > 15) ? 32'd15 : 32'(k - 1));
      chk("sat.icount16",     {16'd0, icount},  32'(k - 1));
      @(negedge CLK);
      #2;
      chk("sat.serv_iwait",   {31'd0, iwait4},  32'd0);
      chk("sat.serv_iload",   iload4,           32'hCAFE0000);
      @(negedge CLK);
    end
    #2;
    chk("sat.final_icount4",  {28'd0, icount4}, 32'd15);
    chk("sat.final_icount16", {16'd0, icount},  32'd16);
    chk("sat.final_dcount4",  {28'd0, dcount4}, 32'd0);
    iREN = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating per-port transaction counters.
REQ-002 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports iREN input 1 (icache read request), iaddr input 32 (icache word address).
REQ-005 SHALL have ports iwait output 1 (icache stall), iload output 32 (icache fill data).
REQ-006 SHALL have ports dREN input 1, dWEN input 1, daddr input 32, dstore input 32 (dcache request, address, write data).
REQ-007 SHALL have ports dwait output 1, dload output 32 (dcache stall, read data).
REQ-008 SHALL have ports ramREN output 1, ramWEN output 1, ramaddr output 32, ramstore output 32, ramload input 32, ramstate input 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-009 SHALL have ports icount output CNT_W, dcount output CNT_W, err output 1 (completed-transaction counts, sticky RAM error flag).

Function
REQ-010 SHALL implement FSM states IDLE, ISERV, DSERV.
REQ-011 IDLE: no RAM request driven; ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-012 IDLE with only (dREN|dWEN) pending -> DSERV next cycle; only iREN -> ISERV; none -> stay IDLE.
REQ-013 IDLE with both ports pending -> DSERV unless last completed grant was data, then ISERV (anti-starvation toggle, flag last_d).
REQ-014 RAM request driven first in cycle after grant decision (one cycle arbitration latency).
REQ-015 DSERV: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins over simultaneous dREN); else ramREN=1.
REQ-016 ISERV: ramREN=1, ramaddr=iaddr, ramWEN=0, ramstore=0.
REQ-017 iwait SHALL be 1 in every cycle except the ISERV cycle where ramstate==ACCESS; dwait likewise for DSERV.
REQ-018 In completing cycle (ACCESS): iload (ISERV) or dload (DSERV, read) = ramload combinationally; otherwise iload=dload=0.
REQ-019 On ACCESS: next state IDLE, last_d updated (1 for DSERV, 0 for ISERV), matching counter incremented, saturating at all-ones.
REQ-020 ramstate FREE or BUSY in a serve state: hold state, keep request and address stable, wait stays 1.
REQ-021 ramstate ERROR in a serve state: set err (sticky until reset), return to IDLE, no counter increment, wait stays 1, last_d unchanged.
REQ-022 Requester deasserting all its request lines while being served: return to IDLE next cycle, no ack, no count.
REQ-023 Back-to-back: no request issued in the IDLE cycle between consecutive transactions (minimum 2 cycles per transaction at zero RAM latency).
REQ-024 Address/data changes during a serve state SHALL pass through combinationally (no internal address latch).

Reset
REQ-025 nRST low SHALL asynchronously force state IDLE, last_d=0, icount=dcount=0, err=0.
REQ-026 During and immediately after reset: ramREN=ramWEN=0, iwait=dwait=1, iload=dload=0, ramaddr=ramstore=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack and no count; first grant after release follows REQ-012/013 with last_d=0.

Verification
REQ-028 iREN=1, iaddr=0x100, ramstate ACCESS in first ISERV cycle, ramload=0xDEADBEEF -> iload=0xDEADBEEF, iwait=0 that cycle only, icount=1.
REQ-029 dWEN=1, dREN=1, daddr=0x40, dstore=0x12345678, ramstate BUSY 3 cycles then ACCESS -> ramWEN=1, ramREN=0 for 4 cycles, dwait=0 on 4th, dcount=1.
REQ-030 iREN and dREN held continuously, RAM ACCESS immediately -> grant order D,I,D,I; ramREN low in each intervening IDLE cycle.
REQ-031 dREN=1, ramstate=ERROR in first DSERV cycle -> err=1, dwait=1, dcount=0, FSM IDLE next cycle; err remains 1 until nRST.
REQ-032 Reset pulse during DSERV with ramstate BUSY -> ramREN=0, dwait=1 immediately, counters 0; after release with both pending, DSERV granted first.
REQ-033 icount preloaded to all-ones via 2^CNT_W-1 completions (CNT_W=4 build) -> one further completion leaves icount=0xF.
